// File: rtl/cell_write_arbiter.sv
// ---------------------------------------------------------------------------
// cell_write_arbiter
//
// Purpose:
//   N-source write-port arbiter for the board-cell memory. Each source posts
//   cell writes independently. The block buffers one write per source,
//   picks one pending write per cycle and drives a single registered write
//   port into the cell RAM. Simultaneous posts are serialised, not lost.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                      undefined -> round-robin starting at a rotating pointer
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active high
//   we_in         in   [N_SRC]        per-source write request
//   cell_x_in     in   [N_SRC*X_W]    packed x coords, source i at [i*X_W +: X_W]
//   cell_y_in     in   [N_SRC*Y_W]    packed y coords, same packing
//   new_value_in  in   [N_SRC*VAL_W]  packed values, same packing
//   busy          out  [N_SRC]        source buffer occupied
//   ack           out  [N_SRC]        one-cycle pulse, source write issued
//   drop          out  [N_SRC]        one-cycle pulse, post discarded (was busy)
//   cell_x_out    out  [X_W]          cell x to memory
//   cell_y_out    out  [Y_W]          cell y to memory
//   we_out        out  1              write enable to memory
//   new_value_out out  [VAL_W]        value to memory
// ---------------------------------------------------------------------------
module cell_write_arbiter #(
    parameter int N_SRC = 2,
    parameter int X_W   = 4,
    parameter int Y_W   = 4,
    parameter int VAL_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         we_in,
    input  logic [N_SRC*X_W-1:0]     cell_x_in,
    input  logic [N_SRC*Y_W-1:0]     cell_y_in,
    input  logic [N_SRC*VAL_W-1:0]   new_value_in,
    output logic [N_SRC-1:0]         busy,
    output logic [N_SRC-1:0]         ack,
    output logic [N_SRC-1:0]         drop,
    output logic [X_W-1:0]           cell_x_out,
    output logic [Y_W-1:0]           cell_y_out,
    output logic                     we_out,
    output logic [VAL_W-1:0]         new_value_out
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] r_pend;
    logic [X_W-1:0]   r_bufX   [N_SRC];
    logic [Y_W-1:0]   r_bufY   [N_SRC];
    logic [VAL_W-1:0] r_bufVal [N_SRC];

    logic             r_weOut;
    logic [N_SRC-1:0] r_ack;
    logic [N_SRC-1:0] r_drop;
    logic [X_W-1:0]   r_xOut;
    logic [Y_W-1:0]   r_yOut;
    logic [VAL_W-1:0] r_valOut;

    logic             w_anyPend;
    logic [PTR_W-1:0] w_winner;
    logic [N_SRC-1:0] w_grant;

`ifdef ARB_FIXED_PRIO_EN

    // Fixed priority: scanning downwards leaves the lowest set index last.
    always_comb begin
        w_anyPend = |r_pend;
        w_winner  = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (r_pend[j]) begin
                w_winner = PTR_W'(j);
            end
        end
    end

`else

    logic [PTR_W-1:0] r_ptr;
    logic [N_SRC-1:0] w_rotPend;
    logic [PTR_W-1:0] w_offset;
    logic [PTR_W:0]   w_sum;

    // Rotate the pending vector so bit 0 is the source at the pointer, find
    // the first set bit, then map the offset back to a source index mod N_SRC.
    always_comb begin
        w_anyPend = |r_pend;
        w_rotPend = N_SRC'({r_pend, r_pend} >> r_ptr);
        w_offset  = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (w_rotPend[j]) begin
                w_offset = PTR_W'(j);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_offset};
        if (w_sum >= (PTR_W+1)'(N_SRC)) begin
            w_sum = w_sum - (PTR_W+1)'(N_SRC);
        end
        w_winner = w_sum[PTR_W-1:0];
    end

    // The pointer moves just past the source that won, so it goes last next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_anyPend) begin
            if (w_winner == PTR_W'(N_SRC - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_winner + 1'b1;
            end
        end
    end

`endif

    always_comb begin
        w_grant = '0;
        if (w_anyPend) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    // Grant and capture use the pending state from before the edge: a source
    // being granted is still busy, so a post from it in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend   <= '0;
            r_weOut  <= 1'b0;
            r_ack    <= '0;
            r_drop   <= '0;
            r_xOut   <= '0;
            r_yOut   <= '0;
            r_valOut <= '0;
            for (int j = 0; j < N_SRC; j++) begin
                r_bufX[j]   <= '0;
                r_bufY[j]   <= '0;
                r_bufVal[j] <= '0;
            end
        end else begin
            r_weOut <= w_anyPend;
            r_ack   <= w_grant;
            r_drop  <= we_in & r_pend;
            // Data outputs hold while idle; memory qualifies them with we_out.
            if (w_anyPend) begin
                r_xOut   <= r_bufX[w_winner];
                r_yOut   <= r_bufY[w_winner];
                r_valOut <= r_bufVal[w_winner];
            end
            for (int j = 0; j < N_SRC; j++) begin
                if (w_grant[j]) begin
                    r_pend[j] <= 1'b0;
                end else if (we_in[j] && !r_pend[j]) begin
                    r_pend[j]   <= 1'b1;
                    r_bufX[j]   <= cell_x_in[j*X_W +: X_W];
                    r_bufY[j]   <= cell_y_in[j*Y_W +: Y_W];
                    r_bufVal[j] <= new_value_in[j*VAL_W +: VAL_W];
                end
            end
        end
    end

    assign busy          = r_pend;
    assign ack           = r_ack;
    assign drop          = r_drop;
    assign we_out        = r_weOut;
    assign cell_x_out    = r_xOut;
    assign cell_y_out    = r_yOut;
    assign new_value_out = r_valOut;

endmodule

// File: tb/tb_cell_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cell_write_arbiter
//
// Drives a 4-source arbiter through directed scenarios and a randomized
// phase. A reference model predicts every output each cycle from the
// arbitration rules: pending flags per source, a circular search from the
// pointer, and capture/drop decided on the pending state before the edge.
// ---------------------------------------------------------------------------
module tb_cell_write_arbiter;

    localparam int NS = 4;

    logic            clk;
    logic            rst;
    logic [NS-1:0]   we_in;
    logic [NS*4-1:0] cell_x_in;
    logic [NS*4-1:0] cell_y_in;
    logic [NS*5-1:0] new_value_in;
    logic [NS-1:0]   busy;
    logic [NS-1:0]   ack;
    logic [NS-1:0]   drop;
    logic [3:0]      cell_x_out;
    logic [3:0]      cell_y_out;
    logic            we_out;
    logic [4:0]      new_value_out;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state
    logic [NS-1:0] mPend;
    logic [3:0]    mX [NS];
    logic [3:0]    mY [NS];
    logic [4:0]    mV [NS];
    int            mPtr;
    logic          eWe;
    logic [NS-1:0] eAck;
    logic [NS-1:0] eDrop;
    logic [3:0]    eX;
    logic [3:0]    eY;
    logic [4:0]    eV;

    cell_write_arbiter #(
        .N_SRC (NS),
        .X_W   (4),
        .Y_W   (4),
        .VAL_W (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .we_in         (we_in),
        .cell_x_in     (cell_x_in),
        .cell_y_in     (cell_y_in),
        .new_value_in  (new_value_in),
        .busy          (busy),
        .ack           (ack),
        .drop          (drop),
        .cell_x_out    (cell_x_out),
        .cell_y_out    (cell_y_out),
        .we_out        (we_out),
        .new_value_out (new_value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predicts the outputs that follow the next rising edge, given the
    // inputs currently driven.
    task automatic modelStep();
        logic [NS-1:0] oldPend;
        int win;
        int start;
        int j;
        if (rst) begin
            mPend = '0;
            for (int i = 0; i < NS; i++) begin
                mX[i] = '0; mY[i] = '0; mV[i] = '0;
            end
            mPtr = 0;
            eWe = 1'b0; eAck = '0; eDrop = '0; eX = '0; eY = '0; eV = '0;
        end else begin
            oldPend = mPend;
            win = -1;
`ifdef ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = mPtr;
`endif
            for (int k = 0; k < NS; k++) begin
                j = (start + k) % NS;
                if (win < 0 && oldPend[j]) win = j;
            end
            eDrop = we_in & oldPend;
            eAck  = '0;
            eWe   = (win >= 0);
            if (win >= 0) begin
                eAck[win] = 1'b1;
                eX = mX[win]; eY = mY[win]; eV = mV[win];
                mPtr = (win + 1) % NS;
                mPend[win] = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                if (we_in[i] && !oldPend[i]) begin
                    mPend[i] = 1'b1;
                    mX[i] = cell_x_in[i*4 +: 4];
                    mY[i] = cell_y_in[i*4 +: 4];
                    mV[i] = new_value_in[i*5 +: 5];
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".busy"}, 32'(busy), 32'(mPend));
        checkVal({tag, ".ack"},  32'(ack),  32'(eAck));
        checkVal({tag, ".drop"}, 32'(drop), 32'(eDrop));
        checkVal({tag, ".we"},   32'(we_out), 32'(eWe));
        checkVal({tag, ".x"},    32'(cell_x_out), 32'(eX));
        checkVal({tag, ".y"},    32'(cell_y_out), 32'(eY));
        checkVal({tag, ".val"},  32'(new_value_out), 32'(eV));
    endtask

    // Drives one cycle of inputs (away from the rising edge), advances the
    // model, then checks all outputs at the following falling edge.
    task automatic applyStimulus(input string tag, input logic r, input logic [NS-1:0] we);
        rst   = r;
        we_in = we;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic setSrc(input int i, input logic [3:0] x, input logic [3:0] y, input logic [4:0] v);
        cell_x_in[i*4 +: 4]    = x;
        cell_y_in[i*4 +: 4]    = y;
        new_value_in[i*5 +: 5] = v;
    endtask

    initial begin : mainSeq
        int posts;
        int writes;
        int drops;
        int cyc;
        int lastCyc;
        int lastGrant;
        int idx;
        int cnt [NS];
        int mx;
        int mn;
        logic [NS-1:0] weVal;
        logic [31:0] expData;
        logic [12:0] dataQ [$];

        rst = 1'b1; we_in = '0;
        cell_x_in = '0; cell_y_in = '0; new_value_in = '0;
        mPend = '0; mPtr = 0;
        eWe = 1'b0; eAck = '0; eDrop = '0; eX = '0; eY = '0; eV = '0;
        for (int i = 0; i < NS; i++) begin
            mX[i] = '0; mY[i] = '0; mV[i] = '0;
        end
        @(negedge clk);

        // Reset state
        applyStimulus("reset", 1'b1, '0);
        applyStimulus("reset", 1'b1, '0);
        checkVal("reset.we_const", 32'(we_out), 0);
        checkVal("reset.busy_const", 32'(busy), 0);
        checkVal("reset.ack_const", 32'(ack), 0);
        checkVal("reset.val_const", 32'(new_value_out), 0);

        // Single write, two-clock latency
        $display("[TB] single write");
        setSrc(0, 4'd3, 4'd7, 5'd5);
        applyStimulus("single.c1", 1'b0, 4'b0001);
        checkVal("single.busy_const", 32'(busy), 32'h1);
        checkVal("single.we_low", 32'(we_out), 0);
        applyStimulus("single.c2", 1'b0, 4'b0000);
        checkVal("single.we_const", 32'(we_out), 1);
        checkVal("single.x_const", 32'(cell_x_out), 3);
        checkVal("single.y_const", 32'(cell_y_out), 7);
        checkVal("single.val_const", 32'(new_value_out), 5);
        checkVal("single.ack_const", 32'(ack), 32'h1);
        applyStimulus("single.c3", 1'b0, 4'b0000);
        checkVal("single.idle_we", 32'(we_out), 0);
        checkVal("single.idle_busy", 32'(busy), 0);

        // Collision from pointer 0
        $display("[TB] collision");
        applyStimulus("coll.rst", 1'b1, '0);
        setSrc(0, 4'd1, 4'd1, 5'd2);
        setSrc(1, 4'd2, 4'd2, 5'd9);
        applyStimulus("coll.c1", 1'b0, 4'b0011);
        applyStimulus("coll.c2", 1'b0, 4'b0000);
        checkVal("coll.first_ack", 32'(ack), 32'h1);
        checkVal("coll.first_val", 32'(new_value_out), 2);
        applyStimulus("coll.c3", 1'b0, 4'b0000);
        checkVal("coll.second_ack", 32'(ack), 32'h2);
        checkVal("coll.second_val", 32'(new_value_out), 9);
        checkVal("coll.second_x", 32'(cell_x_out), 2);
        checkVal("coll.no_drop", 32'(drop), 0);

        // Overflow: second post while busy is dropped
        $display("[TB] overflow");
        setSrc(1, 4'd5, 4'd6, 5'd4);
        applyStimulus("ovf.c1", 1'b0, 4'b0010);
        setSrc(1, 4'd5, 4'd6, 5'd8);
        applyStimulus("ovf.c2", 1'b0, 4'b0010);
        checkVal("ovf.drop_const", 32'(drop), 32'h2);
        checkVal("ovf.val_const", 32'(new_value_out), 4);
        checkVal("ovf.we_const", 32'(we_out), 1);
        applyStimulus("ovf.c3", 1'b0, 4'b0000);
        checkVal("ovf.drop_once", 32'(drop), 0);
        checkVal("ovf.no_second", 32'(we_out), 0);

        // Reset mid-flight
        $display("[TB] reset mid-flight");
        applyStimulus("rmf.post", 1'b0, 4'b0011);
        applyStimulus("rmf.rst", 1'b1, 4'b0000);
        checkVal("rmf.we_zero", 32'(we_out), 0);
        checkVal("rmf.ack_zero", 32'(ack), 0);
        checkVal("rmf.busy_zero", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("rmf.after", 1'b0, 4'b0000);
            checkVal("rmf.no_we", 32'(we_out), 0);
            checkVal("rmf.no_ack", 32'(ack), 0);
        end

        // Back-to-back posts from source 0
        $display("[TB] back-to-back");
        applyStimulus("b2b.rst", 1'b1, '0);
        posts = 0; writes = 0; drops = 0; cyc = 0; lastCyc = -1;
        while (writes < 10 && cyc < 80) begin
            if (we_out) begin
                expData = (dataQ.size() > 0) ? 32'(dataQ.pop_front()) : 32'hFFFF_FFFF;
                checkVal("b2b.data", 32'({cell_x_out, cell_y_out, new_value_out}), expData);
                if (lastCyc >= 0) checkVal("b2b.gap", 32'(cyc - lastCyc), 2);
                lastCyc = cyc;
                writes++;
            end
            drops += int'(drop[0]);
            weVal = '0;
            if (!busy[0] && posts < 10) begin
                setSrc(0, 4'(posts), 4'(posts + 3), 5'(posts * 2 + 1));
                dataQ.push_back({4'(posts), 4'(posts + 3), 5'(posts * 2 + 1)});
                weVal = 4'b0001;
                posts++;
            end
            applyStimulus("b2b", 1'b0, weVal);
            cyc++;
        end
        checkVal("b2b.writes", 32'(writes), 10);
        checkVal("b2b.drops", 32'(drops), 0);

        // Fairness: all sources repost as soon as busy drops
        $display("[TB] fairness");
        applyStimulus("fair.rst", 1'b1, '0);
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        lastGrant = NS - 1;
        for (int c = 0; c < 40; c++) begin
            if (ack != '0) begin
                idx = 0;
                for (int i = 0; i < NS; i++) if (ack[i]) idx = i;
                cnt[idx]++;
`ifndef ARB_FIXED_PRIO_EN
                checkVal("fair.order", 32'(idx), 32'((lastGrant + 1) % NS));
`endif
                lastGrant = idx;
            end
            for (int i = 0; i < NS; i++) setSrc(i, 4'($urandom), 4'($urandom), 5'($urandom));
            applyStimulus("fair", 1'b0, ~busy);
        end
`ifndef ARB_FIXED_PRIO_EN
        mx = cnt[0]; mn = cnt[0];
        for (int i = 1; i < NS; i++) begin
            if (cnt[i] > mx) mx = cnt[i];
            if (cnt[i] < mn) mn = cnt[i];
        end
        checkVal("fair.spread_ok", 32'(mx - mn <= 1), 1);
        checkVal("fair.grants_seen", 32'(mn > 0), 1);
`endif

        // Randomized traffic with occasional reset
        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            cell_x_in    = 16'($urandom);
            cell_y_in    = 16'($urandom);
            new_value_in = 20'($urandom);
            applyStimulus("rand", ($urandom_range(0, 49) == 0), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
